byte_bank_arbiter: RTL and testbench

//   Shares one bank of DEPTH byte-wide storage cells between two requesters (A, B).

---
 rtl/byte_bank_pkg.sv | 14 +
 rtl/byte_bank_byte_bank.sv | 37 +++
 rtl/byte_bank_arbiter.sv | 115 +++++++++++
 tb/tb_byte_bank_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_bank_pkg.sv
// Shared types and constants for the two-requester byte bank arbiter.
package byte_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int   BYTE_W = 8;
    localparam logic REQ_A  = 1'b0;
    localparam logic REQ_B  = 1'b1;

endpackage

// File: rtl/byte_bank_byte_bank.sv
// DEPTH x BYTE_W flop storage with a one-hot per-cell store strobe and a
// combinational read port; addresses outside the bank read as zero.
module byte_bank
    import byte_bank_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DEPTH-1:0]  store,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] cells [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (store[i]) cells[i] <= wdata;
            end
        end
    end

    // Mux by comparison so an out-of-range raddr never indexes past the array.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i)) rdata = cells[i];
        end
    end

endmodule

// File: rtl/byte_bank_arbiter.sv
// Round-robin arbiter sharing one byte bank between requesters A and B;
// each access runs IDLE -> GRANT -> DONE and acks the winner in DONE.
module byte_bank_arbiter
    import byte_bank_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [BYTE_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [BYTE_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [BYTE_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [BYTE_W-1:0] b_rdata,
    output logic              b_err,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshake: a requester holds req high until it sees its one-cycle ack;
    // req is only sampled in IDLE, and rdata/err are meaningful only with ack.
    state_t              state, state_nxt;
    logic                win_q, we_q, last_q, win_nxt, in_range;
    logic [ADDR_W-1:0]   addr_q;
    logic [BYTE_W-1:0]   wdata_q, bank_rdata, rd_result;
    logic [DEPTH-1:0]    store;

    assign win_nxt   = (a_req && b_req) ? ~last_q : b_req;
    assign in_range  = ({{(32-ADDR_W){1'b0}}, addr_q} < 32'(DEPTH));
    assign rd_result = (in_range && !we_q) ? bank_rdata : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        store     = '0;
        unique case (state)
            IDLE:    if (a_req || b_req) state_nxt = GRANT;
            GRANT: begin
                state_nxt = DONE;
                for (int i = 0; i < DEPTH; i++) begin
                    store[i] = we_q && in_range && (addr_q == ADDR_W'(i));
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= REQ_A;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && (a_req || b_req)) begin
            win_q   <= win_nxt;
            we_q    <= win_nxt ? b_we    : a_we;
            addr_q  <= win_nxt ? b_addr  : a_addr;
            wdata_q <= win_nxt ? b_wdata : a_wdata;
        end
    end

    // Ack and read data launch at the end of GRANT so they are visible in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_err   <= 1'b0;
            b_err   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            last_q  <= REQ_B;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            if (state == GRANT) begin
                if (win_q == REQ_A) begin
                    a_ack   <= 1'b1;
                    a_rdata <= rd_result;
                    a_err   <= !in_range;
                end else begin
                    b_ack   <= 1'b1;
                    b_rdata <= rd_result;
                    b_err   <= !in_range;
                end
            end
            if (state == DONE) last_q <= win_q;
        end
    end

    byte_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .store (store),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_byte_bank_arbiter.sv
// Directed bench for byte_bank_arbiter: DEPTH=8 and DEPTH=6 instances share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_byte_bank_arbiter;
  import byte_bank_pkg::*;

  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [7:0]    a_wdata = '0, b_wdata = '0;

  logic [1:0] a_ack, b_ack, a_err, b_err, busy;
  logic [7:0] a_rdata [2];
  logic [7:0] b_rdata [2];
  state_t     dbg_state [2];

  byte_bank_arbiter #(.DEPTH(8), .ADDR_W(AW)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]), .a_err(a_err[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack[0]), .b_rdata(b_rdata[0]), .b_err(b_err[0]),
    .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  byte_bank_arbiter #(.DEPTH(6), .ADDR_W(AW)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]), .a_err(a_err[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack[1]), .b_rdata(b_rdata[1]), .b_err(b_err[1]),
    .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: no ack within cycle budget at %0t", name, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // Each accepted request occupies three cycles; its ack is due one edge after
  // acceptance and the next request can only be taken two edges after that.
  int         edge_n;
  bit         m_act, m_who, m_we, m_last;
  int         m_start;
  int         m_addr;
  logic [7:0] mem [2][8];
  logic [7:0] m_rd [2];
  bit         m_err [2];
  bit         e_ack_a, e_ack_b, e_busy;

  function automatic int depth_of(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_last = 1'b1; edge_n = 0;
      e_ack_a = 1'b0; e_ack_b = 1'b0; e_busy = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 8; i++) mem[d][i] = 8'h00;
    end else begin
      edge_n++;
      if (m_act && (edge_n - m_start) == 2) begin
        m_act = 1'b0;
      end else if (!m_act && (a_req || b_req)) begin
        m_who  = (a_req && b_req) ? !m_last : b_req;
        m_we   = m_who ? b_we : a_we;
        m_addr = m_who ? int'(b_addr) : int'(a_addr);
        m_act = 1'b1; m_start = edge_n; m_last = m_who;
        for (int d = 0; d < 2; d++) begin
          if (m_addr < depth_of(d)) begin
            m_rd[d]  = m_we ? 8'h00 : mem[d][m_addr];
            m_err[d] = 1'b0;
            if (m_we) mem[d][m_addr] = m_who ? b_wdata : a_wdata;
          end else begin
            m_rd[d]  = 8'h00;
            m_err[d] = 1'b1;
          end
        end
      end
      e_busy  = m_act && (edge_n - m_start) <= 1;
      e_ack_a = m_act && (edge_n - m_start) == 1 && !m_who;
      e_ack_b = m_act && (edge_n - m_start) == 1 && m_who;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && checking) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("a_ack[%0d]", d), a_ack[d], e_ack_a);
        check($sformatf("b_ack[%0d]", d), b_ack[d], e_ack_b);
        check($sformatf("busy[%0d]", d), busy[d], e_busy);
        if (e_ack_a) begin
          check($sformatf("a_err[%0d]", d), a_err[d], m_err[d]);
          if (!m_we) check($sformatf("a_rdata[%0d]", d), a_rdata[d], m_rd[d]);
        end
        if (e_ack_b) begin
          check($sformatf("b_err[%0d]", d), b_err[d], m_err[d]);
          if (!m_we) check($sformatf("b_rdata[%0d]", d), b_rdata[d], m_rd[d]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; raises req and returns at the negedge its ack is seen.
  task automatic access(input bit who, input bit we, input int addr,
                        input logic [7:0] wdata, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    if (!who) begin
      a_req = 1'b1; a_we = we; a_addr = addr[AW-1:0];
      a_wdata = we ? wdata : 8'($urandom_range(0, 255));
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr[AW-1:0];
      b_wdata = we ? wdata : 8'($urandom_range(0, 255));
    end
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (!who && a_ack[0]) begin got = 1'b1; a_req = 1'b0; end
      if (who && b_ack[0])  begin got = 1'b1; b_req = 1'b0; end
    end
    if (!got) begin
      a_req = 1'b0; b_req = 1'b0;
      fail_now("access");
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  int lat;
  int acks_a, acks_b, n_acks, cyc, last_a, last_b;
  bit order [$];

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst a_ack", a_ack[d], 1'b0);
      check("rst b_ack", b_ack[d], 1'b0);
      check("rst a_err", a_err[d], 1'b0);
      check("rst b_err", b_err[d], 1'b0);
      check("rst busy", busy[d], 1'b0);
      check("rst a_rdata", a_rdata[d], 8'h00);
      check("rst b_rdata", b_rdata[d], 8'h00);
    end
    rst_n = 1'b1;
    checking = 1'b1;
    repeat (2) @(negedge clk);

    // 1: every cell reads zero after reset
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b0, i, 8'h00, lat);
      check("t1 rdata", a_rdata[0], 8'h00);
      check("t1 err", a_err[0], 1'b0);
    end

    // 2: A writes then reads back; ack two cycles after an idle-start request
    repeat (2) @(negedge clk);
    access(1'b0, 1'b1, 3, 8'hA5, lat);
    check("t2 latency", lat, 2);
    access(1'b0, 1'b0, 3, 8'h00, lat);
    check("t2 readback", a_rdata[0], 8'hA5);

    // 3: simultaneous requests from reset alternate A, B, A, ...
    apply_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd2;
    b_req = 1'b1; b_we = 1'b1; b_addr = 3'd4; b_wdata = 8'h77;
    acks_a = 0; acks_b = 0; cyc = 0; last_a = 0; last_b = 0;
    while ((acks_a < 3 || acks_b < 3) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_ack[0]) begin
        order.push_back(REQ_A);
        check("t3 a wait", ((cyc - last_a) <= 6) ? 1 : 0, 1);
        last_a = cyc; acks_a++;
        if (acks_a == 3) a_req = 1'b0;
      end
      if (b_ack[0]) begin
        order.push_back(REQ_B);
        check("t3 b wait", ((cyc - last_b) <= 6) ? 1 : 0, 1);
        last_b = cyc; acks_b++;
        if (acks_b == 3) b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("t3 ack count", order.size(), 6);
    n_acks = order.size();
    for (int k = 0; k < n_acks; k++)
      check($sformatf("t3 order[%0d]", k), order[k], (k % 2 == 0) ? REQ_A : REQ_B);

    // 4: out-of-range address on the DEPTH=6 instance
    repeat (2) @(negedge clk);
    access(1'b1, 1'b1, 7, 8'h3C, lat);
    check("t4 wr err6", b_err[1], 1'b1);
    check("t4 wr err8", b_err[0], 1'b0);
    access(1'b1, 1'b0, 7, 8'h00, lat);
    check("t4 rd data6", b_rdata[1], 8'h00);
    check("t4 rd err6", b_err[1], 1'b1);
    check("t4 rd data8", b_rdata[0], 8'h3C);

    // 5: reset during GRANT aborts the write and the ack
    repeat (2) @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd1; a_wdata = 8'h5A;
    @(negedge clk);
    check("t5 in grant", dbg_state[0], GRANT);
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    check("t5 busy", busy[0], 1'b0);
    check("t5 ack", a_ack[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    acks_a = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_ack[0]) acks_a++;
    end
    check("t5 no ack", acks_a, 0);
    access(1'b0, 1'b0, 1, 8'h00, lat);
    check("t5 cleared", a_rdata[0], 8'h00);

    // 6: B write then A read of the same cell; A drops req after one cycle
    repeat (2) @(negedge clk);
    access(1'b1, 1'b1, 0, 8'hFF, lat);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h12;
    @(negedge clk);
    a_req = 1'b0;
    acks_a = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack[0]) begin
        acks_a++;
        check("t6 rdata", a_rdata[0], 8'hFF);
      end
    end
    check("t6 ack count", acks_a, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
